trd_sched: RTL and testbench
============================

# trd_sched

Cycle-level thread scheduler that sits beside `thread_ctrl` in the fetch stage and picks which hardware thread issues each cycle. It takes the valid and running thread masks from `thread_ctrl`, rotates among eligible threads round-robin with a configurable quantum, and honours atomic sections. A thread that takes a cache miss is blocked for a fixed latency. It drives `cur_trd` into the PC mux and `nxt_trd` back to `thread_ctrl`.

## Interface
- `N_TRD`, 8: number of hardware threads; thread ids are 3 bits, so this parameter is fixed at 8.
- `QUANTUM`, 1: cycles a thread holds issue before rotation; must be ≥1. A value of 1 gives barrel-style, every-cycle rotation.
- `MISS_LAT`, 4: cycles a thread stays blocked after a miss; must be ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_trd`  in  8  threads that exist (from `thread_ctrl`).
- `run_trd`  in  8  threads not sleeping (from `thread_ctrl`).
- `stall`  in  1  freezes scheduling state.
- `atomic`  in  1  current thread requests to keep issue.
- `miss`  in  1  a cache miss occurred this cycle.
- `miss_trd`  in  3  thread that missed; meaningful only while `miss` is high.
- `cur_trd`  out  3  registered thread that owns issue this cycle.
- `nxt_trd`  out  3  combinational thread that gets issue next.
- `trd_vld`  out  1  `cur_trd` is eligible and may issue.
- `idle`  out  1  no thread is eligible.
- `switch`  out  1  `cur_trd` will change at the next edge.
- `blk_trd`  out  8  registered mask of miss-blocked threads.

## Operation
- Miss-fold mask: `mmask = miss ? onehot(miss_trd) : 0`.
- Eligible mask: `elig = valid_trd & run_trd & ~blk_trd & ~mmask`. A thread that misses in a cycle is therefore excluded in that same cycle.
- `nxt_trd` is the first set bit of `elig`, scanning `cur_trd+1, cur_trd+2, …` modulo 8 and ending at `cur_trd` itself.
  - If only `cur_trd` is eligible, `nxt_trd = cur_trd`.
  - If `elig == 0`, `nxt_trd = cur_trd` and `idle = 1`.
- `trd_vld = elig[cur_trd]`.
- State: `cur_trd` (3 bits), quantum counter `q_cnt` (width `$clog2(QUANTUM)`, minimum 1 bit), and per-thread miss counters `m_cnt[i]` (width `$clog2(MISS_LAT+1)`).
- Switch decision, evaluated in priority order:
  1. `stall` → `switch = 0`; `cur_trd` and `q_cnt` hold.
  2. `!trd_vld` → switch if `nxt_trd != cur_trd`.
  3. `atomic` → hold; `q_cnt` is not advanced.
  4. `q_cnt == QUANTUM-1` → switch if `nxt_trd != cur_trd`; otherwise `q_cnt` wraps to 0.
  5. Otherwise → `q_cnt` increments.
- On a switch, `cur_trd <= nxt_trd` and `q_cnt <= 0`. `switch` is high exactly when `cur_trd` will change.
- A miss on `cur_trd` overrides `atomic`, because the thread is no longer eligible and rule 2 applies.
- Miss block:
  - When `miss` is high, load `m_cnt[miss_trd] <= MISS_LAT` and set `blk_trd[miss_trd] <= 1`.
  - Each counter with a non-zero value decrements every cycle. `blk_trd[i]` clears on the edge where `m_cnt[i]` goes 1→0.
  - A miss on an already-blocked thread reloads its counter to `MISS_LAT`.
  - Miss handling ignores `stall`: loading and counting continue during a stall.
- Kill: if `valid_trd[i]` is 0, `m_cnt[i]` and `blk_trd[i]` clear on the next edge. A simultaneous miss on that thread is ignored.

## Timing
- Reset values: `cur_trd = 0`, `q_cnt = 0`, `blk_trd = 0`, all `m_cnt = 0`, `switch = 0`.
  - With `valid_trd = 0`, the outputs are `idle = 1`, `trd_vld = 0`, `nxt_trd = 0`.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- `nxt_trd`, `trd_vld`, `idle` and `switch` are combinational from the inputs and state, with zero-cycle latency.
- `cur_trd` follows `nxt_trd` one edge after `switch` is high.
- Miss blocking: a miss sampled at edge T (i.e. `miss` high in the cycle before edge T) makes the thread ineligible as follows.
  - In the miss cycle itself, via `mmask`.
  - Through `blk_trd` from edge T through edge T+`MISS_LAT`−1.
  - The thread is eligible again after edge T+`MISS_LAT`.
- Round-robin wrap: 7 → 0.
- Starvation bound: with all 8 threads eligible and no atomic, each thread gets issue within 8×`QUANTUM` cycles.

## Test plan
- Rotation:
  - Stimulus: after reset, `valid_trd = run_trd = 8'hFF`, `QUANTUM = 1`.
  - Response: `cur_trd` steps 0,1,…,7,0 on consecutive edges; `switch = 1` every cycle.
- Sleep skip and idle:
  - Stimulus: `valid_trd = 8'h0B`, `run_trd = 8'h09`.
  - Response: `cur_trd` alternates 0,3,0,3.
  - Then set `run_trd = 0`: `idle = 1`, `trd_vld = 0`, `cur_trd` holds.
- Atomic:
  - Stimulus: 3 threads eligible, `cur_trd = 1`, `atomic` high for 5 cycles.
  - Response: `cur_trd` stays 1 for 5 cycles; on release it moves to 2.
  - A miss on thread 1 during the atomic section switches away on the next edge.
- Miss latency:
  - Stimulus: `MISS_LAT = 4`, threads 0 and 1 eligible, miss on thread 0.
  - Response: `blk_trd[0]` is high for 4 cycles; `cur_trd` stays 1 throughout; thread 0 reissues on the 5th cycle.
  - A repeated miss while blocked extends the block by a full 4 cycles from the reload.
- Stall:
  - Stimulus: hold `stall` for 3 cycles while all threads are eligible; also inject a miss on thread 2 during the stall.
  - Response: `cur_trd` and `q_cnt` are frozen and `switch = 0`.
  - The miss counter still counts down during the stall, so thread 2 is blocked only for the cycles remaining after the stall ends.
- Kill and reset:
  - Stimulus: drop `valid_trd[2]` while thread 2 is blocked.
  - Response: `blk_trd[2]` clears on the next edge.
  - Asserting `rst` mid-run sets `cur_trd = 0` and `blk_trd = 0` immediately.

Source files
------------

// File: rtl/trd_sched.sv
// ---------------------------------------------------------------------------
// trd_sched
// Cycle-level hardware-thread scheduler for the fetch stage. Each cycle it
// picks the thread that owns issue. Eligible threads are rotated round-robin
// with a configurable quantum. An atomic request holds issue on the current
// thread, and a cache miss blocks the missing thread for MISS_LAT cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   valid_trd  threads that exist
//   run_trd    threads that are not sleeping
//   stall      freezes the issue owner and the quantum counter
//   atomic     current thread asks to keep issue
//   miss       a cache miss occurred this cycle
//   miss_trd   thread that missed (meaningful while miss is high)
//   cur_trd    registered thread that owns issue this cycle
//   nxt_trd    combinational thread that gets issue next
//   trd_vld    combinational: cur_trd is eligible this cycle
//   idle       combinational: no thread is eligible
//   switch     combinational: cur_trd changes at the next edge
//   blk_trd    registered mask of miss-blocked threads
// ---------------------------------------------------------------------------
module trd_sched #(
    parameter int unsigned N_TRD    = 8,
    parameter int unsigned QUANTUM  = 1,
    parameter int unsigned MISS_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_TRD-1:0]         valid_trd,
    input  logic [N_TRD-1:0]         run_trd,
    input  logic                     stall,
    input  logic                     atomic,
    input  logic                     miss,
    input  logic [$clog2(N_TRD)-1:0] miss_trd,
    output logic [$clog2(N_TRD)-1:0] cur_trd,
    output logic [$clog2(N_TRD)-1:0] nxt_trd,
    output logic                     trd_vld,
    output logic                     idle,
    output logic                     switch,
    output logic [N_TRD-1:0]         blk_trd
);

    localparam int unsigned TW = $clog2(N_TRD);
    localparam int unsigned QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int unsigned MW = $clog2(MISS_LAT + 1);

    localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);
    localparam logic [MW-1:0] M_LOAD = MW'(MISS_LAT);

    // State
    logic [TW-1:0]    cur_trd_q, cur_trd_d;
    logic [QW-1:0]    q_cnt_q,   q_cnt_d;
    logic [N_TRD-1:0] blk_trd_q, blk_trd_d;
    logic [MW-1:0]    m_cnt_q [N_TRD];
    logic [MW-1:0]    m_cnt_d [N_TRD];

    // Combinational scheduling terms
    logic [N_TRD-1:0] mmask;
    logic [N_TRD-1:0] elig;
    logic [TW-1:0]    nxt_sel;
    logic             sw;

    // A thread missing this cycle is excluded before blk_trd catches up
    always_comb begin
        mmask = '0;
        if (miss) begin
            mmask = N_TRD'(1) << miss_trd;
        end
        elig = valid_trd & run_trd & ~blk_trd_q & ~mmask;
    end

    // Round-robin scan starting just after cur_trd and ending on cur_trd
    always_comb begin
        logic          found;
        logic [TW-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        nxt_sel = cur_trd_q;
        for (int unsigned k = 1; k <= N_TRD; k++) begin
            idx = cur_trd_q + TW'(k);
            if (!found && elig[idx]) begin
                found   = 1'b1;
                nxt_sel = idx;
            end
        end
    end

    // Issue-owner and quantum update, in decreasing priority
    always_comb begin
        sw        = 1'b0;
        cur_trd_d = cur_trd_q;
        q_cnt_d   = q_cnt_q;
        if (stall) begin
            sw = 1'b0;
        end else if (!elig[cur_trd_q]) begin
            // covers a miss on cur_trd, which overrides atomic
            sw = (nxt_sel != cur_trd_q);
        end else if (atomic) begin
            sw = 1'b0;
        end else if (q_cnt_q == Q_LAST) begin
            if (nxt_sel != cur_trd_q) begin
                sw = 1'b1;
            end else begin
                q_cnt_d = '0;
            end
        end else begin
            q_cnt_d = q_cnt_q + QW'(1);
        end
        if (sw) begin
            cur_trd_d = nxt_sel;
            q_cnt_d   = '0;
        end
    end

    // Per-thread miss block; runs regardless of stall, kill wins over miss
    always_comb begin
        blk_trd_d = blk_trd_q;
        for (int unsigned i = 0; i < N_TRD; i++) begin
            m_cnt_d[i] = m_cnt_q[i];
            if (!valid_trd[i]) begin
                m_cnt_d[i]   = '0;
                blk_trd_d[i] = 1'b0;
            end else if (miss && (miss_trd == TW'(i))) begin
                m_cnt_d[i]   = M_LOAD;
                blk_trd_d[i] = 1'b1;
            end else if (m_cnt_q[i] != '0) begin
                m_cnt_d[i] = m_cnt_q[i] - MW'(1);
                if (m_cnt_q[i] == MW'(1)) begin
                    blk_trd_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_trd_q <= '0;
            q_cnt_q   <= '0;
            blk_trd_q <= '0;
            for (int unsigned i = 0; i < N_TRD; i++) begin
                m_cnt_q[i] <= '0;
            end
        end else begin
            cur_trd_q <= cur_trd_d;
            q_cnt_q   <= q_cnt_d;
            blk_trd_q <= blk_trd_d;
            for (int unsigned i = 0; i < N_TRD; i++) begin
                m_cnt_q[i] <= m_cnt_d[i];
            end
        end
    end

    // Outputs
    assign cur_trd = cur_trd_q;
    assign blk_trd = blk_trd_q;
    assign nxt_trd = nxt_sel;
    assign trd_vld = elig[cur_trd_q];
    assign idle    = (elig == '0);
    assign switch  = sw;

endmodule

// File: tb/tb_trd_sched.sv
// ---------------------------------------------------------------------------
// tb_trd_sched
// Drives two schedulers (quantum 1 and quantum 3) with the same inputs.
// A behavioural model tracks, per instance, the issue owner and how many
// cycles it has held issue. Miss blocking is tracked as an absolute
// "blocked until edge N" per thread. Directed phases pin known sequences
// with literal values, then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_trd_sched;

    localparam int L = 4;
    localparam int QV [2] = '{1, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] valid_trd, run_trd;
    logic       stall, atomic, miss;
    logic [2:0] miss_trd;

    logic [2:0] cur_trd [2];
    logic [2:0] nxt_trd [2];
    logic       trd_vld [2];
    logic       idle    [2];
    logic       sw      [2];
    logic [7:0] blk_trd [2];

    int checks = 0;
    int errors = 0;

    trd_sched #(.N_TRD(8), .QUANTUM(1), .MISS_LAT(L)) u_q1 (
        .clk(clk), .rst(rst), .valid_trd(valid_trd), .run_trd(run_trd),
        .stall(stall), .atomic(atomic), .miss(miss), .miss_trd(miss_trd),
        .cur_trd(cur_trd[0]), .nxt_trd(nxt_trd[0]), .trd_vld(trd_vld[0]),
        .idle(idle[0]), .switch(sw[0]), .blk_trd(blk_trd[0])
    );

    trd_sched #(.N_TRD(8), .QUANTUM(3), .MISS_LAT(L)) u_q3 (
        .clk(clk), .rst(rst), .valid_trd(valid_trd), .run_trd(run_trd),
        .stall(stall), .atomic(atomic), .miss(miss), .miss_trd(miss_trd),
        .cur_trd(cur_trd[1]), .nxt_trd(nxt_trd[1]), .trd_vld(trd_vld[1]),
        .idle(idle[1]), .switch(sw[1]), .blk_trd(blk_trd[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cur [2] = '{0, 0};
    int m_held [2] = '{0, 0};      // cycles the owner has held issue in this quantum
    int m_edge = 0;
    int m_bu [8] = '{default: 0};  // thread blocked while m_edge < m_bu[i]

    initial begin
        forever begin
            int         n_cur [2];
            int         n_held [2];
            int         n_bu [8];
            logic [7:0] blk, mm, elig;
            int         nxt;
            bit         found, vld, take;

            @(negedge clk);
            if (rst) begin
                m_cur  = '{0, 0};
                m_held = '{0, 0};
                foreach (m_bu[i]) m_bu[i] = 0;
            end
            for (int i = 0; i < 8; i++) blk[i] = (m_edge < m_bu[i]);
            mm   = miss ? (8'd1 << miss_trd) : 8'd0;
            elig = valid_trd & run_trd & ~blk & ~mm;

            for (int u = 0; u < 2; u++) begin
                nxt   = m_cur[u];
                found = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    if (!found && elig[(m_cur[u] + k) % 8]) begin
                        found = 1'b1;
                        nxt   = (m_cur[u] + k) % 8;
                    end
                end
                vld  = elig[m_cur[u]];
                take = 1'b0;
                n_held[u] = m_held[u];
                if (stall) begin
                    take = 1'b0;
                end else if (!vld) begin
                    take = (nxt != m_cur[u]);
                end else if (atomic) begin
                    take = 1'b0;
                end else if (m_held[u] + 1 >= QV[u]) begin
                    take = (nxt != m_cur[u]);
                    n_held[u] = 0;
                end else begin
                    n_held[u] = m_held[u] + 1;
                end
                if (take) n_held[u] = 0;
                n_cur[u] = take ? nxt : m_cur[u];

                chk($sformatf("cur_trd[%0d]", u), 32'(cur_trd[u]), 32'(m_cur[u]));
                chk($sformatf("blk_trd[%0d]", u), 32'(blk_trd[u]), 32'(blk));
                chk($sformatf("nxt_trd[%0d]", u), 32'(nxt_trd[u]), 32'(nxt));
                chk($sformatf("trd_vld[%0d]", u), 32'(trd_vld[u]), 32'(vld));
                chk($sformatf("idle[%0d]", u), 32'(idle[u]), 32'(elig == 8'd0));
                chk($sformatf("switch[%0d]", u), 32'(sw[u]), 32'(take));
            end

            for (int i = 0; i < 8; i++) begin
                n_bu[i] = m_bu[i];
                if (!valid_trd[i]) n_bu[i] = 0;
                else if (miss && int'(miss_trd) == i) n_bu[i] = m_edge + 1 + L;
            end

            @(posedge clk);
            if (!rst) begin
                m_edge++;
                m_cur  = n_cur;
                m_held = n_held;
                m_bu   = n_bu;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cur(input int t);
        for (int n = 0; n < 20 && int'(cur_trd[0]) != t; n++) tick();
        chk("wait_cur", 32'(cur_trd[0]), 32'(t));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1'b1; valid_trd = 8'h00; run_trd = 8'h00;
        stall = 1'b0; atomic = 1'b0; miss = 1'b0; miss_trd = 3'd0;
        #2;
        chk("rst_cur", 32'(cur_trd[0]), 32'd0);
        chk("rst_blk", 32'(blk_trd[0]), 32'd0);
        chk("rst_idle", 32'(idle[0]), 32'd1);
        chk("rst_vld", 32'(trd_vld[0]), 32'd0);
        chk("rst_nxt", 32'(nxt_trd[0]), 32'd0);
        chk("rst_sw", 32'(sw[0]), 32'd0);
        tick();
        rst = 1'b0;

        // Rotation 0..7,0 with a switch every cycle
        valid_trd = 8'hFF; run_trd = 8'hFF;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk("rot_sw", 32'(sw[0]), 32'd1);
            tick();
            chk("rot_cur", 32'(cur_trd[0]), 32'(k % 8));
        end

        // Sleep skip: only 0 and 3 eligible
        valid_trd = 8'h0B; run_trd = 8'h09;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("skip_cur", 32'(cur_trd[0]), (k % 2 == 1) ? 32'd3 : 32'd0);
        end
        run_trd = 8'h00;
        #1;
        chk("idle_idle", 32'(idle[0]), 32'd1);
        chk("idle_vld", 32'(trd_vld[0]), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("idle_hold", 32'(cur_trd[0]), 32'd3);
        end

        // Atomic hold on thread 1, then a miss breaks it
        valid_trd = 8'h07; run_trd = 8'h07;
        wait_cur(1);
        atomic = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("atomic_hold", 32'(cur_trd[0]), 32'd1);
        end
        atomic = 1'b0;
        tick();
        chk("atomic_release", 32'(cur_trd[0]), 32'd2);
        wait_cur(1);
        atomic = 1'b1; miss = 1'b1; miss_trd = 3'd1;
        #1;
        chk("atomic_miss_sw", 32'(sw[0]), 32'd1);
        chk("atomic_miss_nxt", 32'(nxt_trd[0]), 32'd2);
        tick();
        chk("atomic_miss_cur", 32'(cur_trd[0]), 32'd2);
        atomic = 1'b0; miss = 1'b0;

        // Miss latency with threads 0 and 1
        valid_trd = 8'h03; run_trd = 8'h03;
        wait_cur(1);
        miss = 1'b1; miss_trd = 3'd0;
        tick();
        miss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("miss_blk", 32'(blk_trd[0][0]), 32'd1);
            chk("miss_cur", 32'(cur_trd[0]), 32'd1);
            tick();
        end
        chk("miss_unblk", 32'(blk_trd[0][0]), 32'd0);
        chk("miss_nxt", 32'(nxt_trd[0]), 32'd0);
        tick();
        chk("miss_reissue", 32'(cur_trd[0]), 32'd0);

        // Repeated miss while blocked reloads the full latency
        wait_cur(1);
        miss = 1'b1; miss_trd = 3'd0;
        tick();
        miss = 1'b0;
        tick();
        miss = 1'b1;
        tick();
        miss = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("reload_blk", 32'(blk_trd[0][0]), 32'd1);
            tick();
        end
        chk("reload_unblk", 32'(blk_trd[0][0]), 32'd0);

        // Stall for 3 cycles with a miss on thread 2 in the first
        valid_trd = 8'hFF; run_trd = 8'hFF;
        tick();
        c0 = int'(cur_trd[0]);
        stall = 1'b1; miss = 1'b1; miss_trd = 3'd2;
        tick();
        miss = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("stall_cur", 32'(cur_trd[0]), 32'(c0));
            chk("stall_sw", 32'(sw[0]), 32'd0);
            tick();
        end
        chk("stall_cur_end", 32'(cur_trd[0]), 32'(c0));
        stall = 1'b0;
        chk("stall_blk", 32'(blk_trd[0][2]), 32'd1);
        tick();
        chk("stall_blk_tail", 32'(blk_trd[0][2]), 32'd1);
        tick();
        chk("stall_unblk", 32'(blk_trd[0][2]), 32'd0);

        // Kill a blocked thread
        miss = 1'b1; miss_trd = 3'd2;
        tick();
        miss = 1'b0;
        chk("kill_pre", 32'(blk_trd[0][2]), 32'd1);
        valid_trd = 8'hFB;
        tick();
        chk("kill_clr", 32'(blk_trd[0][2]), 32'd0);
        valid_trd = 8'hFF;

        // Asynchronous reset mid-run
        miss = 1'b1; miss_trd = 3'd5;
        tick();
        miss = 1'b0;
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cur", 32'(cur_trd[0]), 32'd0);
        chk("arst_blk", 32'(blk_trd[0]), 32'd0);
        chk("arst_cur_q3", 32'(cur_trd[1]), 32'd0);
        tick();
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            valid_trd = 8'($urandom) | 8'($urandom) | 8'($urandom);
            run_trd   = 8'($urandom) | 8'($urandom);
            stall     = ($urandom_range(0, 9) == 0);
            atomic    = ($urandom_range(0, 4) == 0);
            miss      = ($urandom_range(0, 5) == 0);
            miss_trd  = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        stall = 1'b0; atomic = 1'b0; miss = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
